// File: rtl/led_pattern_sequencer.sv
// Prescaled LED pattern sequencer: alternate, walking-one rotate, bounce or binary count.
// Optional brightness gating is built when LED_PWM_EN is defined.
module led_pattern_sequencer #(
  parameter int unsigned LED_WIDTH = 8,
  parameter int unsigned TICK_BIT  = 23,
  parameter int unsigned PWM_DUTY  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [1:0]           mode,
  output logic                 step,
  output logic [LED_WIDTH-1:0] LED
);

  localparam int unsigned CNT_W = 32;

  typedef enum logic [1:0] {
    MODE_ALT    = 2'd0,
    MODE_ROT    = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_COUNT  = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

  if (LED_WIDTH < 2 || LED_WIDTH > 32 || TICK_BIT < 1 || TICK_BIT > 30 || PWM_DUTY > 16)
  begin : g_param_range
    $error("led_pattern_sequencer: parameter out of range");
  end

  logic [CNT_W-1:0]     counter_q, counter_d;
  logic [LED_WIDTH-1:0] pattern_q, pattern_d;
  dir_e                 dir_q, dir_d;
  mode_e                cur_mode_q, cur_mode_d;
  logic                 loaded_q, loaded_d;
  logic                 step_q, step_d;

  // Seed value loaded on the first step and on every mode change.
  function automatic logic [LED_WIDTH-1:0] init_pattern(input logic [1:0] m);
    return (m == MODE_COUNT) ? '0 : LED_WIDTH'(1);
  endfunction

  // Prescaler and per-step pattern update.
  always_comb begin
    counter_d  = counter_q;
    pattern_d  = pattern_q;
    dir_d      = dir_q;
    cur_mode_d = cur_mode_q;
    loaded_d   = loaded_q;
    step_d     = 1'b0;

    if (en) begin
      if (counter_q[TICK_BIT]) begin
        counter_d = '0;
        step_d    = 1'b1;
        if (!loaded_q || (mode != cur_mode_q)) begin
          pattern_d  = init_pattern(mode);
          dir_d      = DIR_LEFT;
          cur_mode_d = mode_e'(mode);
          loaded_d   = 1'b1;
        end else begin
          case (cur_mode_q)
            MODE_ALT: begin
              pattern_d = (pattern_q == LED_WIDTH'(1)) ? LED_WIDTH'(2) : LED_WIDTH'(1);
            end
            MODE_ROT: begin
              pattern_d = {pattern_q[LED_WIDTH-2:0], pattern_q[LED_WIDTH-1]};
            end
            MODE_BOUNCE: begin
              // Reverse on reaching an end so the end LED is lit for a single step.
              if (dir_q == DIR_LEFT) begin
                if (pattern_q[LED_WIDTH-1]) begin
                  pattern_d = pattern_q >> 1;
                  dir_d     = DIR_RIGHT;
                end else begin
                  pattern_d = pattern_q << 1;
                end
              end else begin
                if (pattern_q[0]) begin
                  pattern_d = pattern_q << 1;
                  dir_d     = DIR_LEFT;
                end else begin
                  pattern_d = pattern_q >> 1;
                end
              end
            end
            MODE_COUNT: begin
              pattern_d = pattern_q + LED_WIDTH'(1);
            end
            default: begin
              pattern_d = pattern_q;
            end
          endcase
        end
      end else begin
        counter_d = counter_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      counter_q  <= '0;
      pattern_q  <= '0;
      dir_q      <= DIR_LEFT;
      cur_mode_q <= MODE_ALT;
      loaded_q   <= 1'b0;
      step_q     <= 1'b0;
    end else begin
      counter_q  <= counter_d;
      pattern_q  <= pattern_d;
      dir_q      <= dir_d;
      cur_mode_q <= cur_mode_d;
      loaded_q   <= loaded_d;
      step_q     <= step_d;
    end
  end

  assign step = step_q;

`ifdef LED_PWM_EN
  logic [3:0] pwm_cnt_q, pwm_cnt_d;
  logic       pwm_on_q, pwm_on_d;

  // Free-running brightness window; duty of 16 keeps the gate permanently open.
  always_comb begin
    pwm_cnt_d = pwm_cnt_q + 4'(1);
    pwm_on_d  = (5'(pwm_cnt_q) < 5'(PWM_DUTY));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt_q <= '0;
      pwm_on_q  <= 1'b0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
      pwm_on_q  <= pwm_on_d;
    end
  end

  assign LED = pattern_q & {LED_WIDTH{pwm_on_q}};
`else
  assign LED = pattern_q;
`endif

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Directed bench for led_pattern_sequencer with LED_WIDTH=4, TICK_BIT=2 (5-cycle step period).
module tb_led_pattern_sequencer;

  localparam int unsigned LED_WIDTH = 4;
  localparam int unsigned TICK_BIT  = 2;
  localparam int unsigned STEP_CAP  = 64;

  logic                 clk;
  logic                 rst;
  logic                 en;
  logic [1:0]           mode;
  logic                 step;
  logic [LED_WIDTH-1:0] led;

  int n_checks;
  int n_pass;

  led_pattern_sequencer #(
    .LED_WIDTH(LED_WIDTH),
    .TICK_BIT (TICK_BIT),
    .PWM_DUTY (4)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .mode(mode),
    .step(step),
    .LED (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Wait (from a negedge) for the next step pulse; check latency and LED value.
  task automatic expect_step(input string tag, input int exp_cyc, input logic [LED_WIDTH-1:0] exp_led);
    int cyc;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!step && cyc < STEP_CAP);
    check({tag, "_cyc"}, 32'(cyc), 32'(exp_cyc));
    check({tag, "_led"}, 32'(led), 32'(exp_led));
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int steps_seen;
    int led_moved;
    logic [LED_WIDTH-1:0] exp_pat;

    n_checks = 0;
    n_pass   = 0;
    rst  = 1'b1;
    en   = 1'b1;
    mode = 2'd0;

    idle(3);
    check("rst_led", 32'(led), 32'd0);
    check("rst_step", 32'(step), 32'd0);
    rst = 1'b0;

    // Alternate mode: first step 5 cycles after release loads 1.
    expect_step("alt0", 5, 4'd1);
    expect_step("alt1", 5, 4'd2);
    expect_step("alt2", 5, 4'd1);
    expect_step("alt3", 5, 4'd2);

    // Freeze for 20 cycles two cycles into the period.
    idle(2);
    en = 1'b0;
    steps_seen = 0;
    led_moved  = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (step) steps_seen++;
      if (led !== 4'd2) led_moved++;
    end
    check("freeze_step", 32'(steps_seen), 32'd0);
    check("freeze_led", 32'(led_moved), 32'd0);
    en = 1'b1;
    expect_step("resume", 3, 4'd1);

    // Dropping en on the tick cycle suppresses that step.
    idle(4);
    en = 1'b0;
    @(negedge clk);
    check("tick_supp_step", 32'(step), 32'd0);
    check("tick_supp_led", 32'(led), 32'd1);
    en = 1'b1;
    expect_step("tick_late", 1, 4'd2);

    // Rotate.
    mode = 2'd1;
    expect_step("rot0", 5, 4'd1);
    expect_step("rot1", 5, 4'd2);
    expect_step("rot2", 5, 4'd4);
    expect_step("rot3", 5, 4'd8);
    expect_step("rot4", 5, 4'd1);
    expect_step("rot5", 5, 4'd2);
    expect_step("rot6", 5, 4'd4);

    // Mode change mid-period takes effect at the next step.
    idle(2);
    mode = 2'd3;
    @(negedge clk);
    check("mode_sw_hold", 32'(led), 32'd4);
    expect_step("cnt_load", 2, 4'd0);
    exp_pat = 4'd0;
    for (int i = 1; i <= 16; i++) begin
      exp_pat = exp_pat + 4'd1;
      expect_step($sformatf("cnt%0d", i), 5, exp_pat);
    end

    // Bounce.
    mode = 2'd2;
    expect_step("bnc0", 5, 4'd1);
    expect_step("bnc1", 5, 4'd2);
    expect_step("bnc2", 5, 4'd4);
    expect_step("bnc3", 5, 4'd8);
    expect_step("bnc4", 5, 4'd4);
    expect_step("bnc5", 5, 4'd2);
    expect_step("bnc6", 5, 4'd1);
    expect_step("bnc7", 5, 4'd2);
    expect_step("bnc8", 5, 4'd4);
    expect_step("bnc9", 5, 4'd8);
    expect_step("bnc10", 5, 4'd4);

    // Asynchronous reset between edges while sweeping right.
    idle(2);
    #2 rst = 1'b1;
    #1;
    check("arst_led", 32'(led), 32'd0);
    check("arst_step", 32'(step), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    expect_step("post_rst0", 5, 4'd1);
    expect_step("post_rst1", 5, 4'd2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
